instr_mem: RTL and testbench
============================

// Module: instr_mem
// PURPOSE
//   Instruction memory feeding the program counter. Responds to the 8-bit PC count (addr) with the
//   32-bit instruction at that address, registered, on the PC's instruction_in.
//   Has a byte-serial program loader (valid/ready handshake) that fills the memory word by word
//   from an external source. While a load is in progress, fetch returns NOP.
// PARAMETERS
//   AW      8        address width; depth = 2**AW words
//   DW      32       instruction width; multiple of 8
//   NOP     32'h0    instruction driven during reset and while loading
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   reset        in   1      asynchronous, active-high; clears all control state
//   addr         in   AW     fetch address (PC count)
//   instruction  out  DW     registered fetch data, to PC instruction_in
//   instr_valid  out  1      instruction holds mem[addr] sampled on the previous edge
//   load_start   in   1      begin load; sampled only in IDLE
//   load_len     in   AW     number of words to load; 0 means 2**AW
//   load_byte    in   8      loader data byte
//   load_valid   in   1      load_byte valid
//   load_ready   out  1      loader accepts a byte this cycle (valid && ready = transfer)
//   loading      out  1      high in LOAD state
//   load_done    out  1      one-cycle pulse after the final word is written
// BEHAVIOUR
//   Reset values (async): state=IDLE; instruction=NOP; instr_valid=0; load_ready=0; loading=0;
//     load_done=0; wr_ptr=0; byte_idx=0; words_left=0; assembly register=0. Memory array is not cleared.
//   FSM states: IDLE, LOAD, DONE.
//   IDLE: every edge instruction<=mem[addr], instr_valid<=1 (1-cycle read latency).
//     load_start=1 -> LOAD; wr_ptr<=0; byte_idx<=0; words_left<=load_len (0 maps to 2**AW).
//     Fetch in that same edge still completes normally.
//   LOAD: load_ready=1 and loading=1 (both combinational from state); instruction<=NOP; instr_valid<=0.
//     Each transfer places load_byte in lane byte_idx; little-endian, byte 0 -> bits[7:0].
//     byte_idx increments mod DW/8.
//     On the transfer with byte_idx=DW/8-1, the word (3 held bytes + current byte) is written to
//       mem[wr_ptr]; wr_ptr wraps mod 2**AW; words_left decrements.
//     When that write empties words_left -> DONE. load_valid=0 -> hold; no state change.
//     load_start is ignored in LOAD.
//   DONE: one cycle. load_done=1, load_ready=0, instruction=NOP, instr_valid=0. Then -> IDLE.
//     First valid fetch (instr_valid=1) appears two edges after the final byte transfer.
//   No read/write collision is possible: reads are suppressed outside IDLE.
//   Reset mid-load: returns to IDLE immediately. Words already written keep their values.
//     A partially assembled word is discarded. No load_done pulse.
//   addr changes every cycle are legal. Output tracks addr with exactly one cycle of latency.
// TESTING
//   1. Assert reset, release -> instruction=0, instr_valid=0 until first edge; then instr_valid=1.
//   2. load_len=2, bytes 78,56,34,12,EF,BE,AD,DE (valid every cycle) -> load_done pulse one cycle
//      after 8th byte. Then addr=0 -> 32'h12345678 next cycle; addr=1 -> 32'hDEADBEEF.
//   3. Same load with load_valid gapped every other cycle -> identical contents; load_ready stays 1;
//      instruction=NOP throughout.
//   4. load_len=0 (256 words, byte k = k[7:0]) -> done after 1024 transfers; mem[255] = 32'hFFFEFDFC.
//      Second load of 1 word starts at wr_ptr=0 (overwrites mem[0] only).
//   5. Reset after 6 bytes of a 2-word load -> mem[0] written, mem[1] unchanged, state IDLE,
//      no load_done; load_start pulse during LOAD ignored.
//   6. Sweep addr 0,1,2,... one per cycle in IDLE -> instruction equals mem[addr-1 cycle] every cycle.

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory for the PC: registered 1-cycle fetch, plus a byte-serial
// little-endian program loader (valid/ready) that fills the array word by word.
//   state | meaning
//   IDLE  | fetching mem[addr] every edge, waiting for load_start
//   LOAD  | accepting bytes, fetch forced to NOP
//   DONE  | single-cycle load_done pulse, fetch still NOP
module instr_mem #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter logic [DW-1:0] NOP = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] instruction,
    output logic          instr_valid,
    input  logic          load_start,
    input  logic [AW-1:0] load_len,
    input  logic [7:0]    load_byte,
    input  logic          load_valid,
    output logic          load_ready,
    output logic          loading,
    output logic          load_done
);
    localparam int NB    = DW / 8;
    localparam int BIW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BIW-1:0] byte_idx_q, byte_idx_d;
    logic [AW:0]    words_left_q, words_left_d;
    logic [DW-1:0]  asm_q, asm_d;
    logic [DW-1:0]  instruction_q, instruction_d;
    logic           instr_valid_q, instr_valid_d;

    logic xfer;
    logic last_byte;
    logic word_wr;
    logic final_word;

    assign xfer       = (state_q == LOAD) && load_valid;
    assign last_byte  = (byte_idx_q == BIW'(NB - 1));
    assign word_wr    = xfer && last_byte;
    assign final_word = word_wr && (words_left_q == (AW + 1)'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (final_word) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == LOAD);
        loading    = (state_q == LOAD);
        load_done  = (state_q == DONE);
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        byte_idx_d    = byte_idx_q;
        words_left_d  = words_left_q;
        asm_d         = asm_q;
        instruction_d = NOP;
        instr_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                instruction_d = mem[addr];
                instr_valid_d = 1'b1;
                if (load_start) begin
                    wr_ptr_d     = '0;
                    byte_idx_d   = '0;
                    // a length of zero means the full array
                    words_left_d = (load_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, load_len};
                end
            end
            LOAD: begin
                if (xfer) begin
                    for (int i = 0; i < NB; i++) begin
                        if (byte_idx_q == BIW'(i)) asm_d[i*8 +: 8] = load_byte;
                    end
                    byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
                    if (last_byte) begin
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        words_left_d = words_left_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            byte_idx_q    <= '0;
            words_left_q  <= '0;
            asm_q         <= '0;
            instruction_q <= NOP;
            instr_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            byte_idx_q    <= byte_idx_d;
            words_left_q  <= words_left_d;
            asm_q         <= asm_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // array contents survive reset; the write word includes the byte arriving now
    always_ff @(posedge clk) begin
        if (word_wr) mem[wr_ptr_q] <= asm_d;
    end

    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: directed load/fetch steps with randomized data, gaps and
// addresses, compared against an array model of the instruction memory.
module tb_instr_mem;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_len = '0;
    logic [7:0]    load_byte = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          loading;
    logic          load_done;

    instr_mem #(.AW(AW), .DW(DW), .NOP(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_byte   (load_byte),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .loading     (loading),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [256];
    bit          ref_ok  [256];
    logic [7:0]  bq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        addr = a;
        step();
        check("fetch_valid", 32'(instr_valid), 32'h1);
        if (ref_ok[a]) check("fetch_data", instruction, ref_mem[a]);
    endtask

    // gap_mode: 0 valid every cycle, 1 every other cycle, 2 random
    task automatic run_load(input int len, input int gap_mode, input bit poke);
        int  nwords;
        int  total;
        int  sent;
        int  cycles;
        bit  v;
        bit  last;
        nwords = (len == 0) ? 256 : len;
        total  = nwords * 4;
        sent   = 0;
        cycles = 0;
        load_len   = 8'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_enter", {30'b0, loading, load_ready}, 32'h3);
        while (sent < total && cycles < total * 4 + 16) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            load_valid = v;
            load_byte  = v ? bq[sent] : 8'($urandom);
            load_start = poke ? 1'($urandom) : 1'b0;
            if (poke) load_len = 8'($urandom);
            step();
            cycles++;
            if (v) sent++;
            last = (sent == total);
            check("load_done", 32'(load_done), 32'(last));
            check("load_busy", {30'b0, loading, load_ready}, last ? 32'h0 : 32'h3);
            check("load_nop", instruction, 32'h0);
            check("load_invalid", 32'(instr_valid), 32'h0);
        end
        check("load_timeout", 32'(sent), 32'(total));
        load_valid = 1'b0;
        load_start = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            ref_mem[w] = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
            ref_ok[w]  = 1'b1;
        end
        step();
        check("done_clear", {30'b0, load_done, loading}, 32'h0);
        check("done_nop", {instruction[30:0], instr_valid}, 32'h0);
        step();
        check("first_fetch_valid", 32'(instr_valid), 32'h1);
        if (ref_ok[addr]) check("first_fetch_data", instruction, ref_mem[addr]);
    endtask

    initial begin
        int nlen;
        // reset state, then first fetch edge
        #12;
        check("rst_instr", instruction, 32'h0);
        check("rst_flags", {27'b0, instr_valid, load_ready, loading, load_done, 1'b0}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_hold_valid", 32'(instr_valid), 32'h0);
        step();
        check("post_rst_valid", 32'(instr_valid), 32'h1);
        check("post_rst_idle", {30'b0, loading, load_done}, 32'h0);

        // directed two-word load
        bq = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 0, 1'b0);
        fetch(8'd0);
        check("word0_const", instruction, 32'h12345678);
        fetch(8'd1);
        check("word1_const", instruction, 32'hDEADBEEF);

        // random-length random-data load, random gaps, stray load_start
        nlen = $urandom_range(3, 8);
        bq = {};
        for (int k = 0; k < nlen * 4; k++) bq.push_back(8'($urandom));
        run_load(nlen, 2, 1'b1);
        for (int a = 0; a < nlen; a++) fetch(8'(a));

        // directed load again, valid every other cycle
        bq = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 1, 1'b0);
        fetch(8'd1);
        check("gap_word1_const", instruction, 32'hDEADBEEF);
        fetch(8'd0);
        check("gap_word0_const", instruction, 32'h12345678);
        fetch(8'd2);

        // full-depth load, byte k = k[7:0]
        bq = {};
        for (int k = 0; k < 1024; k++) bq.push_back(8'(k));
        run_load(0, 0, 1'b0);
        fetch(8'd255);
        check("mem255_const", instruction, 32'hFFFEFDFC);

        // single-word reload restarts at address 0
        bq = {};
        for (int k = 0; k < 4; k++) bq.push_back(8'($urandom));
        run_load(1, 2, 1'b0);
        fetch(8'd0);
        fetch(8'd1);
        check("mem1_kept_const", instruction, 32'h07060504);

        // full sweep, one address per cycle
        for (int a = 0; a < 256; a++) fetch(8'(a));

        // reset after six bytes of a two-word load
        bq = {};
        for (int k = 0; k < 8; k++) bq.push_back(8'($urandom));
        load_len   = 8'd2;
        load_start = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            load_valid = 1'b1;
            load_byte  = bq[k];
            load_start = 1'b1;
            load_len   = 8'($urandom);
            step();
            check("abort_busy", {30'b0, loading, load_done}, 32'h2);
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        ref_mem[0] = {bq[3], bq[2], bq[1], bq[0]};
        #2;
        reset = 1'b1;
        #1;
        check("abort_flags", {28'b0, instr_valid, load_ready, loading, load_done}, 32'h0);
        check("abort_nop", instruction, 32'h0);
        reset = 1'b0;
        fetch(8'd0);
        check("abort_no_done", {30'b0, loading, load_done}, 32'h0);
        fetch(8'd1);
        check("abort_mem1_const", instruction, 32'h07060504);
        fetch(8'd2);
        check("abort_still_idle", {30'b0, loading, load_done}, 32'h0);

        // random address stream
        for (int i = 0; i < 100; i++) fetch(8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
